elastic_pipe: RTL and testbench

- Parametrised, bubble-collapsing register pipeline of DEPTH stages, each WIDTH bits wide, with a valid/ready handshake on both ends.
- Successor to the single-clock blocking/non-blocking register chain exercise. Generalises it to arbitrary width and depth, and adds backpressure, flush and occupancy reporting.
- Sits between datapath units that need fixed nominal latency but must tolerate downstream stalls.

---
 rtl/elastic_pipe_pkg.sv | 27 ++
 rtl/elastic_pipe_stage.sv | 43 ++++
 rtl/elastic_pipe.sv | 95 +++++++++
 tb/tb_elastic_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_pkg.sv
// ------------------------------------------------------------------
// elastic_pipe_pkg : shared defaults and helpers for elastic_pipe
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package elastic_pipe_pkg;

  localparam int EP_DEFAULT_WIDTH = 32;
  localparam int EP_DEFAULT_DEPTH = 4;

  // Ceiling log2 usable in parameter defaults on tools lacking $clog2.
  function automatic int ep_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/elastic_pipe_stage.sv
// ------------------------------------------------------------------
// pipe_stage : one valid/data register slice of elastic_pipe
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = EP_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Flush drops valid only; data is kept so an emptied output holds its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= v_in;
      r_data  <= d_in;
    end
  end

  assign d_out = r_data;
  assign v_out = r_valid;

endmodule

`default_nettype wire

// File: rtl/elastic_pipe.sv
// ------------------------------------------------------------------
// elastic_pipe : bubble-collapsing valid/ready register pipeline
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = EP_DEFAULT_WIDTH,
  parameter int DEPTH = EP_DEFAULT_DEPTH,
  parameter int CNT_W = ep_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             w_push;
  logic             w_pop;
  logic             w_carry;
  logic [CNT_W-1:0] r_count;

  // Advance chain walks back from the output; in_ready therefore depends
  // combinationally on out_ready by design.
  always_comb begin
    w_adv   = '0;
    w_carry = out_ready || !w_valid[DEPTH-1];
    w_adv[DEPTH-1] = w_carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_carry  = !w_valid[i] || w_carry;
      w_adv[i] = w_carry;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (w_adv[i]),
        .d_in  (in_data),
        .v_in  (in_valid),
        .d_out (w_data[i]),
        .v_out (w_valid[i])
      );
    end else begin : g_rest
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (w_adv[i]),
        .d_in  (w_data[i-1]),
        .v_in  (w_valid[i-1]),
        .d_out (w_data[i]),
        .v_out (w_valid[i])
      );
    end
  end

  assign in_ready  = w_adv[0] && !flush && !reset;
  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_elastic_pipe.sv
// ------------------------------------------------------------------
// tb_elastic_pipe : directed self-checking bench for elastic_pipe
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_elastic_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;

  logic        d1_flush;
  logic        d1_in_valid;
  logic        d1_in_ready;
  logic [7:0]  d1_in_data;
  logic        d1_out_valid;
  logic        d1_out_ready;
  logic [7:0]  d1_out_data;
  logic [0:0]  d1_count;

  int n_tests = 0;
  int n_fail  = 0;

  // DEPTH=1 directed table: stimulus and hand-derived expectations per cycle
  logic       t_vin  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] t_din  [8] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44};
  logic       t_ordy [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       t_irdy [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       t_ov   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] t_od   [8] = '{8'h00, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h00};
  logic [0:0] t_cnt  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  elastic_pipe #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  elastic_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (d1_flush),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
    .in_data   (d1_in_data),
    .out_valid (d1_out_valid),
    .out_ready (d1_out_ready),
    .out_data  (d1_out_data),
    .count     (d1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a word offered: nothing may be accepted
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
    d1_flush = 1'b0; d1_in_valid = 1'b0; d1_in_data = 8'h00; d1_out_ready = 1'b0;
    #2;
    check("rst_in_ready_0", in_ready, 1'b0);
    tick();
    check("rst_in_ready_1", in_ready, 1'b0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_d1_out_valid", d1_out_valid, 1'b0);
    tick();
    check("rst_no_accept", count, 3'd0);

    // Streaming 1..10 with out_ready high
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 10) begin
        in_valid = 1'b1;
        in_data  = 32'(k + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check($sformatf("s2_in_ready[%0d]", k), in_ready, 1'b1);
      check($sformatf("s2_out_valid[%0d]", k), out_valid, (k >= 4));
      if (k >= 4) check($sformatf("s2_out_data[%0d]", k), out_data, 32'(k - 3));
      if (k >= 4 && k <= 10) check($sformatf("s2_count[%0d]", k), count, 3'd4);
      tick();
    end
    #1;
    check("s2_drained_valid", out_valid, 1'b0);
    check("s2_drained_count", count, 3'd0);
    check("s2_empty_holds_data", out_data, 32'd10);

    // Backpressure: A0..A3 fill the pipe, A4 is refused
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(k);
      #1;
      check($sformatf("s3_in_ready[%0d]", k), in_ready, (k < 4));
      tick();
    end
    #1;
    check("s3_full_count", count, 3'd4);
    check("s3_full_out_valid", out_valid, 1'b1);
    check("s3_full_out_data", out_data, 32'hA0);
    check("s3_full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("s3_pushpop_in_ready", in_ready, 1'b1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("s3_pushpop_count", count, 3'd4);
    check("s3_pushpop_out_data", out_data, 32'hA1);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check($sformatf("s3_drain_valid[%0d]", j), out_valid, 1'b1);
      check($sformatf("s3_drain_data[%0d]", j), out_data, 32'hA1 + 32'(j));
      tick();
    end
    #1;
    check("s3_drained_valid", out_valid, 1'b0);
    check("s3_drained_count", count, 3'd0);

    // Bubble collapse: X, two idles, Y, two idles with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1111_0000;
    #1;
    check("s4_in_ready_x", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      check($sformatf("s4_in_ready_gap[%0d]", j), in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b1; in_data = 32'h2222_0000;
    #1;
    check("s4_in_ready_y", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      check($sformatf("s4_in_ready_tail[%0d]", j), in_ready, 1'b1);
      tick();
    end
    #1;
    check("s4_count", count, 3'd2);
    check("s4_out_valid", out_valid, 1'b1);
    check("s4_out_x", out_data, 32'h1111_0000);
    out_ready = 1'b1;
    tick();
    check("s4_out_y_valid", out_valid, 1'b1);
    check("s4_out_y", out_data, 32'h2222_0000);
    tick();
    check("s4_empty_valid", out_valid, 1'b0);
    check("s4_empty_count", count, 3'd0);

    // Flush with three words in flight and a concurrent offer of 0x77
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 * 32'(j + 1);
      tick();
    end
    #1;
    check("s5_pre_count", count, 3'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    #1;
    check("s5_flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("s5_post_count", count, 3'd0);
    check("s5_post_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("s5_no_emit[%0d]", j), out_valid, 1'b0);
    end

    // Streaming again with reset pulsed in cycle 6
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      logic expv;
      reset = (k == 6);
      if (k < 10) begin
        in_valid = 1'b1;
        in_data  = 32'(k + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      expv = (k >= 4 && k <= 6) || (k >= 11 && k <= 13);
      check($sformatf("s6_out_valid[%0d]", k), out_valid, expv);
      if (expv) check($sformatf("s6_out_data[%0d]", k), out_data, 32'(k - 3));
      check($sformatf("s6_in_ready[%0d]", k), in_ready, (k != 6));
      if (k == 7) begin
        check("s6_post_rst_data", out_data, 32'h0);
        check("s6_post_rst_count", count, 3'd0);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    check("s6_end_valid", out_valid, 1'b0);
    check("s6_end_count", count, 3'd0);

    // DEPTH=1 with alternating out_ready
    for (int k = 0; k < 8; k++) begin
      d1_in_valid  = t_vin[k];
      d1_in_data   = t_din[k];
      d1_out_ready = t_ordy[k];
      #1;
      check($sformatf("d1_in_ready[%0d]", k), d1_in_ready, t_irdy[k]);
      check($sformatf("d1_out_valid[%0d]", k), d1_out_valid, t_ov[k]);
      if (t_ov[k]) check($sformatf("d1_out_data[%0d]", k), d1_out_data, t_od[k]);
      check($sformatf("d1_count[%0d]", k), d1_count, t_cnt[k]);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
